// File: rtl/div_sign_ctrl32_if.sv
`default_nettype none
// ============================================================================
// div_sign_ctrl32_if
// Bundles the execute-stage request/response signals and the divider-core
// handshake of the signed divide front-end.
// Revision: 1.0 - initial release
// ============================================================================
interface div_sign_ctrl32_if #(
  parameter int WIDTH = 32
) ();
  // execute-stage side
  logic             valid_in;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  // unsigned divider core side
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_start;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  // controller view
  modport slave (
    input  valid_in, funct3, rs1, rs2, div_busy, div_q, div_r,
    output ready, done, result, div_a, div_b, div_start
  );

  // environment view (execute stage plus divider core)
  modport master (
    output valid_in, funct3, rs1, rs2, div_busy, div_q, div_r,
    input  ready, done, result, div_a, div_b, div_start
  );
endinterface
`default_nettype wire

// File: rtl/div_sign_ctrl32.sv
`default_nettype none
// ============================================================================
// div_sign_ctrl32
// Sign/special-case front-end for RISC-V DIV/DIVU/REM/REMU. Converts operands
// to magnitudes, resolves divide-by-zero and signed overflow locally, drives
// the unsigned core handshake and re-applies signs to the registered result.
// Revision: 1.0 - initial release
// ============================================================================
module div_sign_ctrl32 #(
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rstLow,
  div_sign_ctrl32_if.slave bus
);

  localparam logic [WIDTH-1:0] c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_want_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_result;

  logic             w_ready;
  logic             w_done;
  logic             w_start;
  logic             w_accept;
  logic             w_is_signed;
  logic             w_want_rem;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_special;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH-1:0] w_core_res;

  // Only 100/110 are signed and only 110/111 want the remainder; every
  // other code therefore falls through to plain DIVU.
  assign w_is_signed = bus.funct3[2] & ~bus.funct3[0];
  assign w_want_rem  = bus.funct3[2] &  bus.funct3[1];
  assign w_accept    = (r_state == S_IDLE) && bus.valid_in;

  // |x| of the most negative value wraps to itself, which is the correct
  // unsigned magnitude for the core.
  assign w_mag_a = (w_is_signed && bus.rs1[WIDTH-1]) ? -bus.rs1 : bus.rs1;
  assign w_mag_b = (w_is_signed && bus.rs2[WIDTH-1]) ? -bus.rs2 : bus.rs2;

  assign w_div_zero = (bus.rs2 == '0);
  assign w_overflow = w_is_signed && (bus.rs1 == c_MIN_NEG) && (bus.rs2 == c_ALL_ONES);
  assign w_special  = w_div_zero || w_overflow;

  // Divide-by-zero wins over overflow; its remainder is the raw dividend.
  assign w_special_res = w_div_zero ? (w_want_rem ? bus.rs1 : c_ALL_ONES)
                                    : (w_want_rem ? '0      : c_MIN_NEG);

  assign w_core_res = r_want_rem ? (r_neg_r ? -bus.div_r : bus.div_r)
                                 : (r_neg_q ? -bus.div_q : bus.div_q);

  assign bus.ready     = w_ready;
  assign bus.done      = w_done;
  assign bus.div_start = w_start;
  assign bus.result    = r_result;
  assign bus.div_a     = r_div_a;
  assign bus.div_b     = r_div_b;

  // State register.
  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_in) begin
          w_state_nxt = w_special ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.div_busy) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/sign capture on accept; result load on special accept or core completion.
  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_want_rem <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_want_rem <= w_want_rem;
      r_neg_q    <= w_is_signed & (bus.rs1[WIDTH-1] ^ bus.rs2[WIDTH-1]);
      r_neg_r    <= w_is_signed & bus.rs1[WIDTH-1];
      r_div_a    <= w_mag_a;
      r_div_b    <= w_mag_b;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == S_WAIT) && !bus.div_busy) begin
      r_result <= w_core_res;
    end
  end

endmodule
`default_nettype wire
